// File: rtl/div_unit_seq_pkg.sv
// Shared constants for the sequential RV32M divider: operand width, OP encodings, FSM states.
package div_unit_seq_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_ADJ  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Bit 0 of the OP code selects unsigned, bit 1 selects remainder.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_seq_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial subtract, keep or restore.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // Shifted remainder needs one extra bit: it can exceed XLEN bits before the subtract.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls the pipe via busy, pulses done.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per clock, XLEN steps
// ADJ   | sign fix-up, result registered
// FIN   | done pulse; start here launches the next op
module div_unit_seq
    import div_unit_seq_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [1:0]      op_q;
    logic            neg_quo;
    logic            neg_rem;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;

    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] adj_res;
    logic            can_start;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_d),
        .quo_next (quo_d)
    );

    assign sign1    = is_signed_op(op) & data1[XLEN-1];
    assign sign2    = is_signed_op(op) & data2[XLEN-1];
    assign mag1     = sign1 ? (~data1 + 1'b1) : data1;
    assign mag2     = sign2 ? (~data2 + 1'b1) : data2;
    assign div_zero = (data2 == '0);
    assign overflow = is_signed_op(op) && (data1 == INT_MIN) && (data2 == '1);
    assign special  = div_zero | overflow;
    assign can_start = start && (state == ST_IDLE || state == ST_FIN);

    // Divide-by-zero and INT_MIN/-1 bypass the iteration and finish on the start edge.
    always_comb begin
        special_res = '1;
        if (div_zero) begin
            special_res = is_rem_op(op) ? data1 : '1;
        end else if (overflow) begin
            special_res = is_rem_op(op) ? '0 : INT_MIN;
        end
    end

    always_comb begin
        adj_res = quo_q;
        if (is_rem_op(op_q)) begin
            adj_res = neg_rem ? (~rem_q + 1'b1) : rem_q;
        end else begin
            adj_res = neg_quo ? (~quo_q + 1'b1) : quo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_q     <= OP_DIV;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (can_start) begin
                        if (special) begin
                            result_q <= special_res;
                            state    <= ST_FIN;
                        end else begin
                            op_q    <= op;
                            neg_quo <= sign1 ^ sign2;
                            neg_rem <= sign1;
                            rem_q   <= '0;
                            quo_q   <= mag1;
                            dvs_q   <= mag2;
                            cnt     <= '0;
                            state   <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_ADJ;
                    end
                end
                ST_ADJ: begin
                    result_q <= adj_res;
                    state    <= ST_FIN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state == ST_CALC) || (state == ST_ADJ);
    assign done   = (state == ST_FIN);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Randomized and directed bench for div_unit_seq against an arithmetic reference model.
module tb_div_unit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt = 0;
    int total    = 0;

    div_unit_seq dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .op     (op),
        .data1  (data1),
        .data2  (data2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M semantics computed with wide signed arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint la, lb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (o)
            2'b00: return 32'(la / lb);
            2'b01: return a / b;
            2'b10: return 32'(la % lb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        data1 = $urandom;
        data2 = $urandom;
    endtask

    // Counts edges after the start edge until done is seen, plus cycles with busy high.
    task automatic wait_done(output int edges, output int busy_n);
        edges = 0;
        busy_n = 0;
        while (done !== 1'b1 && edges < 60) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; data1 = '0; data2 = '0;
        #3;
        total++;
        if ({busy, done, result} !== 34'd0) $display("FAIL reset_state: busy=%b done=%b result=%h, want 0/0/0", busy, done, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [11] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10};
        logic [31:0] t_a  [11] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7, 5, 5, 32'h8000_0000, 32'h8000_0000, 5, 5};
        logic [31:0] t_b  [11] = '{7, 7, 2, 2, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        logic [31:0] t_r  [11] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 5, 32'h8000_0000, 0, 32'hFFFF_FFFF, 5};
        bit          t_f  [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int edges, busy_n;
        for (int i = 0; i < 11; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            wait_done(edges, busy_n);
            total++;
            if (result !== t_r[i] || done !== 1'b1) $display("FAIL directed_result[%0d]: got %h done=%b, want %h", i, result, done, t_r[i]);
            else pass_cnt++;
            total++;
            if (edges != (t_f[i] ? 0 : 33)) $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, edges, t_f[i] ? 0 : 33);
            else pass_cnt++;
            total++;
            if (busy_n != (t_f[i] ? 0 : 33)) $display("FAIL directed_busy[%0d]: got %0d busy cycles, want %0d", i, busy_n, t_f[i] ? 0 : 33);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || result !== t_r[i]) $display("FAIL directed_pulse[%0d]: done=%b result=%h, want 0/%h", i, done, result, t_r[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b, exp;
        int edges, busy_n;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            exp = model(o, a, b);
            launch(o, a, b);
            wait_done(edges, busy_n);
            total++;
            if (result !== exp || done !== 1'b1) $display("FAIL random_result[%0d] op=%0d %h/%h: got %h, want %h", i, o, a, b, result, exp);
            else pass_cnt++;
            total++;
            if (edges != (is_fast(o, a, b) ? 0 : 33)) $display("FAIL random_latency[%0d]: got %0d edges, want %0d", i, edges, is_fast(o, a, b) ? 0 : 33);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush;
        logic [31:0] prev;
        int edges, busy_n, seen;
        launch(2'b01, 32'd1000, 32'd10);
        wait_done(edges, busy_n);
        prev = 32'd100;
        launch(2'b01, 32'hDEAD_BEEF, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prev) $display("FAIL flush_abort: busy=%b done=%b result=%h, want 0/0/%h", busy, done, result, prev);
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL flush_quiet: got %0d active cycles, want 0", seen);
        else pass_cnt++;
        launch(2'b00, 32'hFFFF_FF9C, 32'd7);
        wait_done(edges, busy_n);
        total++;
        if (result !== 32'hFFFF_FFF2 || edges != 33) $display("FAIL flush_restart: got %h after %0d edges, want fffffff2 after 33", result, edges);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'b01; data1 = 32'd50; data2 = 32'd5;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFF2) $display("FAIL flush_beats_start: busy=%b done=%b result=%h, want 0/0/fffffff2", busy, done, result);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int edges, busy_n, extra;
        launch(2'b01, 32'd1000, 32'd3);
        wait_done(edges, busy_n);
        total++;
        if (result !== 32'd333 || done !== 1'b1) $display("FAIL b2b_first: got %h done=%b, want 0000014d", result, done);
        else pass_cnt++;
        launch(2'b10, 32'hFFFF_FF9C, 32'd7);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept_in_fin: busy=%b done=%b, want 1/0", busy, done);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; op = 2'b01; data1 = 32'd9; data2 = 32'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
            extra++;
        end
        wait_done(edges, busy_n);
        total++;
        if (result !== 32'hFFFF_FFFE || extra + edges != 33) $display("FAIL b2b_ignore_busy_start: got %h after %0d edges, want fffffffe after 33", result, extra + edges);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int seen;
        launch(2'b01, 32'd12345, 32'd11);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result} !== 34'd0) $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0/0/0", busy, done, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1 || done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL reset_mid_idle: got %0d active cycles, want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
